// File: rtl/if_stage_pkg.sv
// Shared CPU front-end definitions for the instruction-fetch stage.
//   - FETCH/HOLD/DROP state encodings for the IF controller
//   - default reset PC and NOP instruction word
//   - mask that forces word alignment on fetch addresses
package if_stage_pkg;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INS  = 32'h0000_0000;

    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : capture pc_4_in/ins_in and mark the entry live
//   flush           : kill the entry (valid=0, ins=NOP_INS); wins over load
//   bubble          : mark the entry dead without touching its payload
//   pc_4_in, ins_in : payload to capture on load
//   valid, pc_4, ins: registered outputs towards ID
// With none of load/flush/bubble asserted the register holds its contents.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INS = DEF_NOP_INS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic        bubble,
    input  logic [31:0] pc_4_in,
    input  logic [31:0] ins_in,
    output logic        valid,
    output logic [31:0] pc_4,
    output logic [31:0] ins
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc_4  <= '0;
            ins   <= NOP_INS;
        end else if (flush) begin
            valid <= 1'b0;
            ins   <= NOP_INS;
        end else if (load) begin
            valid <= 1'b1;
            pc_4  <= pc_4_in;
            ins   <= ins_in;
        end else if (bubble) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch handshake, one-entry hold buffer,
// redirect handling and the IF/ID register.
//   clk, rst_n   : clock, asynchronous active-low reset
//   imem_req     : fetch request valid (low in HOLD and during reset)
//   imem_addr    : fetch address (always word aligned)
//   imem_ready   : imem_rdata valid; completes the outstanding request
//   imem_rdata   : fetched instruction word
//   stall        : hold IF/ID and stop the PC
//   redirect     : taken branch/jump from ID; flushes IF/ID, beats stall
//   redirect_pc  : redirect target, low two bits ignored
//   id_valid     : IF/ID holds a live instruction
//   id_pc_4      : fetch address of id_ins plus 4
//   id_ins       : registered instruction word
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INS  = DEF_NOP_INS
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc_4,
    output logic [31:0] id_ins
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] hold_ins;
    logic [31:0] hold_pc_4;
    logic [31:0] pend_pc;
    logic        started;   // first clock after reset release has occurred

    logic        fire;
    logic [31:0] pc_next4;
    logic [31:0] target;

    logic        ifid_load;
    logic        ifid_flush;
    logic        ifid_bubble;
    logic [31:0] ifid_pc_4;
    logic [31:0] ifid_ins;

    // The request waits for the first edge after reset so that it never
    // depends combinationally on the reset pin itself.
    assign imem_req  = started && (state != HOLD);
    assign imem_addr = pc;
    assign fire      = imem_req && imem_ready;
    assign pc_next4  = pc + 32'd4;
    assign target    = redirect_pc & ALIGN_MASK;

    // IF/ID control. Without stall the ID stage consumes its instruction
    // every cycle, so a cycle with nothing new to deliver becomes a bubble.
    always_comb begin
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ifid_bubble = 1'b0;
        ifid_pc_4   = pc_next4;
        ifid_ins    = imem_rdata;
        if (redirect) begin
            ifid_flush = 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) begin
                        if (fire) ifid_load   = 1'b1;
                        else      ifid_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_load = 1'b1;
                        ifid_pc_4 = hold_pc_4;
                        ifid_ins  = hold_ins;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            hold_ins  <= '0;
            hold_pc_4 <= '0;
            pend_pc   <= '0;
            started   <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                FETCH: begin
                    if (redirect) begin
                        // An outstanding request must still be completed by
                        // memory; park the target until its data is dropped.
                        if (fire || !imem_req) begin
                            pc <= target;
                        end else begin
                            pend_pc <= target;
                            state   <= DROP;
                        end
                    end else if (fire) begin
                        pc <= pc_next4;
                        if (stall) begin
                            hold_ins  <= imem_rdata;
                            hold_pc_4 <= pc_next4;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= FETCH;
                    end else if (!stall) begin
                        state <= FETCH;
                    end
                end
                DROP: begin
                    if (fire) begin
                        pc    <= redirect ? target : pend_pc;
                        state <= FETCH;
                    end else if (redirect) begin
                        pend_pc <= target;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INS (NOP_INS)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .bubble  (ifid_bubble),
        .pc_4_in (ifid_pc_4),
        .ins_in  (ifid_ins),
        .valid   (id_valid),
        .pc_4    (id_pc_4),
        .ins     (id_ins)
    );

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by randomized traffic.
// The reference model tracks the program-order fetch address and the list of
// instructions owed to ID; a monitor compares every delivered instruction.
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc_4;
    logic [31:0] id_ins;

    if_stage #(
        .RESET_PC (RPC),
        .NOP_INS  (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_pc_4     (id_pc_4),
        .id_ins      (id_ins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] prog_pc;
    bit          draining;
    bit          prev_wait;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        prog_pc   = RPC;
        draining  = 1'b0;
        prev_wait = 1'b0;
    endtask

    // Drive one cycle of stimulus at the falling edge, update the model with
    // what the coming rising edge must do, and return just after that edge.
    task automatic step(input bit rdy, input bit stl, input bit rdr, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        if (prev_wait) begin
            check("req_held", {31'd0, imem_req}, 32'd1);
            check("addr_stable", imem_addr, prev_addr);
        end
        imem_ready  = rdy && imem_req;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = tgt;
        imem_rdata  = imem_ready ? mem_word(imem_addr) : $urandom;
        if (rdr) begin
            sb.delete();
            if (imem_ready)    draining = 1'b0;
            else if (imem_req) draining = 1'b1;
            prog_pc = {tgt[31:2], 2'b00};
        end else if (imem_ready) begin
            if (draining) begin
                draining = 1'b0;
            end else begin
                check("fetch_addr", imem_addr, prog_pc);
                e.pc4 = prog_pc + 32'd4;
                e.ins = mem_word(prog_pc);
                sb.push_back(e);
                prog_pc = prog_pc + 32'd4;
            end
        end
        prev_wait = imem_req && !imem_ready;
        prev_addr = imem_addr;
        @(posedge clk);
        #2;
    endtask

    // Monitor: after each edge decide what IF/ID must show.
    initial begin : monitor
        logic        pv;
        logic [31:0] pp;
        logic [31:0] pi;
        exp_t        e;
        pv = 1'b0; pp = '0; pi = NOP;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pv = 1'b0; pp = '0; pi = NOP;
                continue;
            end
            if (redirect) begin
                check("flush_valid", {31'd0, id_valid}, 32'd0);
                check("flush_ins", id_ins, NOP);
            end else if (stall) begin
                check("stall_valid", {31'd0, id_valid}, {31'd0, pv});
                check("stall_pc4", id_pc_4, pp);
                check("stall_ins", id_ins, pi);
            end else if (id_valid) begin
                if (sb.size() == 0) begin
                    check("valid_without_fetch", {31'd0, id_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("id_pc_4", id_pc_4, e.pc4);
                    check("id_ins", id_ins, e.ins);
                end
            end
            pv = id_valid; pp = id_pc_4; pi = id_ins;
        end
    end

    initial begin : stimulus
        logic [31:0] tgt;
        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        model_reset();

        // Reset values
        #12;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_ins", id_ins, NOP);
        check("rst_pc4", id_pc_4, 32'd0);
        check("rst_addr", imem_addr, RPC);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        check("req_before_edge", {31'd0, imem_req}, 32'd0);

        // Back-to-back fetches with ready tied high
        step(0, 0, 0, 0);
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        check("first_valid", {31'd0, id_valid}, 32'd0);
        for (int unsigned i = 1; i <= 3; i++) begin
            step(1, 0, 0, 0);
            check("stream_pc4", id_pc_4, 32'(4 * i));
            check("stream_addr", imem_addr, 32'(4 * i));
            check("stream_valid", {31'd0, id_valid}, 32'd1);
        end
        step(1, 0, 0, 0);
        check("addr_10", imem_addr, 32'h10);

        // Stall three cycles while the word at 0x10 returns
        step(1, 1, 0, 0);
        check("hold_req", {31'd0, imem_req}, 32'd0);
        check("hold_pc4", id_pc_4, 32'h10);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("hold_pc4_late", id_pc_4, 32'h10);
        step(0, 0, 0, 0);
        check("release_ins", id_ins, mem_word(32'h10));
        check("release_pc4", id_pc_4, 32'h14);
        check("release_addr", imem_addr, 32'h14);

        // Redirect while 0x20 is outstanding, data delayed two cycles
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
        check("addr_20", imem_addr, 32'h20);
        step(0, 0, 1, 32'h0040_0003);
        check("drop_addr", imem_addr, 32'h20);
        check("drop_valid", {31'd0, id_valid}, 32'd0);
        step(0, 0, 0, 0);
        check("drop_addr2", imem_addr, 32'h20);
        step(1, 0, 0, 0);
        check("drop_done_addr", imem_addr, 32'h0040_0000);
        check("drop_done_valid", {31'd0, id_valid}, 32'd0);
        step(1, 0, 0, 0);
        check("target_pc4", id_pc_4, 32'h0040_0004);
        check("target_valid", {31'd0, id_valid}, 32'd1);

        // Stall and redirect together
        step(1, 1, 1, 32'h0000_0080);
        check("sr_valid", {31'd0, id_valid}, 32'd0);
        check("sr_ins", id_ins, NOP);
        check("sr_addr", imem_addr, 32'h80);

        // Wrap of pc+4
        step(1, 0, 1, 32'hFFFF_FFFC);
        check("wrap_addr_pre", imem_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        check("wrap_pc4", id_pc_4, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        step(1, 0, 0, 0);
        check("after_wrap_addr", imem_addr, 32'h4);

        // Reset in the middle of DROP
        step(0, 0, 1, 32'h0000_1234);
        check("pre_rst_addr", imem_addr, 32'h4);
        #3;
        rst_n = 1'b0; imem_ready = 1'b0; redirect = 1'b0; stall = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'd0, id_valid}, 32'd0);
        check("mid_rst_ins", id_ins, NOP);
        check("mid_rst_pc4", id_pc_4, 32'd0);
        check("mid_rst_addr", imem_addr, RPC);
        model_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, RPC);

        // Randomized traffic
        for (int unsigned n = 0; n < 3000; n++) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            step($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, tgt);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INS, default 32'h0000_0000, meaning the instruction word placed in id_ins on reset or flush.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  32  fetch address; bits [1:0] always 0.
REQ-007 SHALL have port imem_ready  input  1  imem_rdata valid this cycle; completes the request.
REQ-008 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-009 SHALL have port stall  input  1  hazard unit: hold IF/ID and stop the PC.
REQ-010 SHALL have port redirect  input  1  taken branch or jump resolved in ID.
REQ-011 SHALL have port redirect_pc  input  32  branch or jump target; bits [1:0] ignored.
REQ-012 SHALL have port id_valid  output  1  IF/ID holds a live instruction.
REQ-013 SHALL have port id_pc_4  output  32  fetch address of id_ins plus 4.
REQ-014 SHALL have port id_ins  output  32  registered instruction word.

Function
REQ-015 SHALL implement a 3-state FSM with states FETCH, HOLD and DROP.
REQ-016 SHALL drive imem_req=1 in FETCH and DROP, drive imem_req=0 in HOLD, and drive imem_addr=pc.
REQ-017 SHALL keep imem_addr stable while imem_req=1 and imem_ready=0.
REQ-018 SHALL, in FETCH with imem_ready=1, stall=0 and redirect=0, load id_ins=imem_rdata, id_pc_4=pc+4 and id_valid=1, and set pc<=pc+4; sustained throughput is 1 instruction/cycle and IF/ID latency is 1 cycle after imem_ready.
REQ-019 SHALL, in FETCH with imem_ready=1, stall=1 and redirect=0, capture the word and its pc+4 into a one-entry hold buffer, set pc<=pc+4, go to HOLD, and leave IF/ID unchanged.
REQ-020 SHALL, in HOLD with stall=0 and redirect=0, move the hold buffer into IF/ID with id_valid=1 and go to FETCH.
REQ-021 SHALL, in FETCH with imem_ready=0 and stall=1, leave IF/ID unchanged and keep the request outstanding.
REQ-022 SHALL treat redirect=1 as a flush: id_valid<=0, id_ins<=NOP_INS, and the hold buffer discarded; redirect has priority over stall.
REQ-023 SHALL, on redirect in FETCH with imem_ready=1 or in HOLD, set pc<={redirect_pc[31:2],2'b00}, go to FETCH, and discard the returned word.
REQ-024 SHALL, on redirect in FETCH with imem_ready=0, store the target in a pending register, go to DROP, and keep imem_addr unchanged.
REQ-025 SHALL, in DROP, discard imem_rdata when imem_ready=1, then set pc<=pending target and go to FETCH.
REQ-026 SHALL, on a new redirect while in DROP, overwrite the pending target with the newest one.
REQ-027 SHALL, when redirect=1 and imem_ready=1 occur in the same DROP cycle, use the new redirect_pc.
REQ-028 SHALL keep id_valid=0 throughout DROP.
REQ-029 SHALL compute pc+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-030 SHALL, while stall=1, hold id_* at their previous values unless redirect=1.

Reset
REQ-031 SHALL, on rst_n=0, immediately set pc=RESET_PC, state=FETCH, id_valid=0, id_ins=NOP_INS, id_pc_4=0, hold buffer empty, and pending register=0.
REQ-032 SHALL drive imem_req=0 while rst_n=0.
REQ-033 SHALL assert imem_req at the first clk edge after rst_n deasserts.
REQ-034 SHALL abandon any request in flight when reset asserts mid-operation; an imem_ready arriving after reset is not possible by memory contract.

Structure
REQ-035 SHALL place the FSM state encoding (FETCH=2'd0, HOLD=2'd1, DROP=2'd2), NOP_INS and RESET_PC defaults in the shared CPU package.
REQ-036 SHALL implement the IF/ID register (valid/pc_4/ins with load, hold and flush) as one sub-module if_id_reg; PC, hold buffer and FSM stay in if_stage.

Verification
REQ-037 SHALL cover reset then imem_ready tied to 1 with RESET_PC=0: imem_addr 0,4,8; id_pc_4 4,8,C one cycle later; id_valid=1 from cycle 2.
REQ-038 SHALL cover stall=1 for 3 cycles while imem_ready=1 at pc=0x10: HOLD entered; IF/ID frozen; after release id_ins = word from 0x10, id_pc_4=0x14, next fetch at 0x14.
REQ-039 SHALL cover redirect with redirect_pc=0x0040_0003 while a request is outstanding at 0x20 with ready delayed 2 cycles: DROP entered; 0x20 data discarded; next imem_addr=0x0040_0000; id_valid=0 until a fresh word arrives.
REQ-040 SHALL cover stall=1 and redirect=1 in the same cycle: id_valid=0, id_ins=NOP_INS, pc=target.
REQ-041 SHALL cover pc=0xFFFF_FFFC fetched: id_pc_4=0x0000_0000 and the next imem_addr=0.
REQ-042 SHALL cover rst_n asserted mid-DROP: outputs immediately at reset values; after release the first imem_addr=RESET_PC.
